// File: rtl/store_drain_arbiter_if.sv
// Bundle for the store-drain arbiter: store retire, load request, fence handshake,
// and the shared data-memory request channel.
interface store_drain_arbiter_if #(
    parameter int DEPTH = 4
) ();
    logic                         st_commit;
    logic [31:0]                  st_addr;
    logic [31:0]                  st_data;
    logic [3:0]                   st_mask;
    logic                         st_ready;
    logic                         ld_req;
    logic [31:0]                  ld_addr;
    logic                         ld_ready;
    logic                         fence_req;
    logic                         fence_done;
    logic                         mem_req;
    logic                         mem_we;
    logic [31:0]                  mem_addr;
    logic [31:0]                  mem_wdata;
    logic [3:0]                   mem_wmask;
    logic                         mem_ready;
    logic [$clog2(DEPTH+1)-1:0]   sb_count;

    // The arbiter's side of the bundle.
    modport master (
        input  st_commit, st_addr, st_data, st_mask, ld_req, ld_addr, fence_req, mem_ready,
        output st_ready, ld_ready, fence_done, mem_req, mem_we, mem_addr, mem_wdata,
        output mem_wmask, sb_count
    );

    // Commit, LSU and memory side of the bundle.
    modport slave (
        output st_commit, st_addr, st_data, st_mask, ld_req, ld_addr, fence_req, mem_ready,
        input  st_ready, ld_ready, fence_done, mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_wmask, sb_count
    );
endinterface

// File: rtl/store_drain_arbiter.sv
// In-order committed-store buffer that shares one DMEM request port with loads;
// loads bypass stores unless they hit a buffered word, stores are forced on full/starve/fence.
module store_drain_arbiter #(
    parameter int DEPTH        = 4,
    parameter int LOW_WATER    = 1,
    parameter int STARVE_LIMIT = 8
) (
    input logic                   clk,
    input logic                   rst,
    store_drain_arbiter_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] LOW_COUNT  = CW'(LOW_WATER);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {NORMAL, FULL_DRAIN, FENCE} state_t;

    state_t           state;
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       mask_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [SW-1:0]    starve;

    logic        push;
    logic        pop;
    logic        ld_hazard;
    logic        store_sel;
    logic        ld_sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        ld_ready;

    assign bus.st_ready   = (count != FULL_COUNT);
    assign push           = bus.st_commit && bus.st_ready;
    assign pop            = mem_req && mem_we && bus.mem_ready;
    assign bus.fence_done = (state == FENCE) && (count == '0);
    assign bus.sb_count   = count;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_wmask  = mem_wmask;
    assign bus.ld_ready   = ld_ready;

    // Word-granular match against every buffered store; byte masks are deliberately ignored.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:2] == bus.ld_addr[31:2])) begin
                ld_hazard = bus.ld_req;
            end
        end
    end

    always_comb begin
        store_sel = (count != '0) &&
                    ((state != NORMAL) || !bus.ld_req || ld_hazard || (starve == STARVE_MAX));
        ld_sel    = !store_sel && bus.ld_req;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        ld_ready  = 1'b0;
        if (store_sel) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q[head];
            mem_wdata = data_q[head];
            mem_wmask = mask_q[head];
        end else if (ld_sel) begin
            mem_req  = 1'b1;
            mem_addr = bus.ld_addr;
            ld_ready = bus.mem_ready;
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Payload storage needs no reset: valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
            mask_q[tail] <= bus.st_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
            starve  <= '0;
            state   <= NORMAL;
        end else begin
            if (push) begin
                valid_q[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            count <= count_next;

            if (pop || (count == '0)) begin
                starve <= '0;
            end else if (ld_sel && (starve != STARVE_MAX)) begin
                starve <= starve + SW'(1);
            end

            // Fence outranks a full-buffer drain; fence exit looks at the registered count.
            case (state)
                NORMAL: begin
                    if (bus.fence_req) begin
                        state <= FENCE;
                    end else if (count == FULL_COUNT) begin
                        state <= FULL_DRAIN;
                    end
                end
                FULL_DRAIN: begin
                    if (bus.fence_req) begin
                        state <= FENCE;
                    end else if (count_next <= LOW_COUNT) begin
                        state <= NORMAL;
                    end
                end
                FENCE: begin
                    if (count == '0) begin
                        state <= NORMAL;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end
endmodule
